// File: rtl/sync_edge_filter_if.sv
// Signal bundle between the edge filter and its user: the synchronized level
// and counter clear in, the debounced level, edge pulses and event counts out.
interface sync_edge_filter_if #(
    parameter int CNTW = 8
);
    logic            sync_in;
    logic            clr;
    logic            level_out;
    logic            rise_pls;
    logic            fall_pls;
    logic [CNTW-1:0] edge_cnt;
    logic [CNTW-1:0] glitch_cnt;

    modport master (
        output sync_in,
        output clr,
        input  level_out,
        input  rise_pls,
        input  fall_pls,
        input  edge_cnt,
        input  glitch_cnt
    );

    modport slave (
        input  sync_in,
        input  clr,
        output level_out,
        output rise_pls,
        output fall_pls,
        output edge_cnt,
        output glitch_cnt
    );
endinterface

// File: rtl/sync_edge_filter.sv
// Debounces an already-synchronized level: a change is accepted only after
// FILTCYC consecutive samples of the new value; shorter excursions are counted as glitches.
module sync_edge_filter #(
    parameter int FILTCYC = 4,
    parameter int CNTW    = 8
) (
    input logic               clk,
    input logic               reset,
    sync_edge_filter_if.slave bus
);
    typedef enum logic [1:0] {
        LOW     = 2'd0,
        QUAL_HI = 2'd1,
        HIGH    = 2'd2,
        QUAL_LO = 2'd3
    } state_t;

    // qcnt holds the number of new-value samples seen so far; the FILTCYC-th
    // one is recognised when qcnt already equals FILTCYC-1.
    localparam logic [7:0] QLAST = 8'(FILTCYC - 1);

    state_t          state_reg;
    logic [7:0]      qcnt_reg;
    logic            level_reg;
    logic            rise_reg;
    logic            fall_reg;
    logic [CNTW-1:0] edge_cnt_reg;
    logic [CNTW-1:0] glitch_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= LOW;
            qcnt_reg       <= '0;
            level_reg      <= 1'b0;
            rise_reg       <= 1'b0;
            fall_reg       <= 1'b0;
            edge_cnt_reg   <= '0;
            glitch_cnt_reg <= '0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
                LOW: begin
                    if (bus.sync_in) begin
                        state_reg <= QUAL_HI;
                        qcnt_reg  <= 8'd1;
                    end
                end
                QUAL_HI: begin
                    if (!bus.sync_in) begin
                        state_reg <= LOW;
                        qcnt_reg  <= '0;
                        if (glitch_cnt_reg != '1)
                            glitch_cnt_reg <= glitch_cnt_reg + CNTW'(1);
                    end else if (qcnt_reg == QLAST) begin
                        state_reg <= HIGH;
                        qcnt_reg  <= '0;
                        level_reg <= 1'b1;
                        rise_reg  <= 1'b1;
                        if (edge_cnt_reg != '1)
                            edge_cnt_reg <= edge_cnt_reg + CNTW'(1);
                    end else begin
                        qcnt_reg <= qcnt_reg + 8'd1;
                    end
                end
                HIGH: begin
                    if (!bus.sync_in) begin
                        state_reg <= QUAL_LO;
                        qcnt_reg  <= 8'd1;
                    end
                end
                QUAL_LO: begin
                    if (bus.sync_in) begin
                        state_reg <= HIGH;
                        qcnt_reg  <= '0;
                        if (glitch_cnt_reg != '1)
                            glitch_cnt_reg <= glitch_cnt_reg + CNTW'(1);
                    end else if (qcnt_reg == QLAST) begin
                        state_reg <= LOW;
                        qcnt_reg  <= '0;
                        level_reg <= 1'b0;
                        fall_reg  <= 1'b1;
                        if (edge_cnt_reg != '1)
                            edge_cnt_reg <= edge_cnt_reg + CNTW'(1);
                    end else begin
                        qcnt_reg <= qcnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    qcnt_reg  <= '0;
                end
            endcase
            // Placed last so a clear wins over an increment in the same cycle.
            if (bus.clr) begin
                edge_cnt_reg   <= '0;
                glitch_cnt_reg <= '0;
            end
        end
    end

    assign bus.level_out  = level_reg;
    assign bus.rise_pls   = rise_reg;
    assign bus.fall_pls   = fall_reg;
    assign bus.edge_cnt   = edge_cnt_reg;
    assign bus.glitch_cnt = glitch_cnt_reg;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Bench for sync_edge_filter: directed scenarios plus randomized traffic
// compared against a run-length model of the debounce rules.
module tb_sync_edge_filter;
    localparam int FILTCYC = 4;
    localparam int CNTW    = 8;
    localparam logic [CNTW-1:0] CMAX = '1;

    logic clk;
    logic reset;

    sync_edge_filter_if #(.CNTW(CNTW)) bus ();

    sync_edge_filter #(.FILTCYC(FILTCYC), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model: filtered level plus length of the current run of
    // samples that disagree with it.
    logic            m_level;
    int              m_run;
    logic            m_rise;
    logic            m_fall;
    logic [CNTW-1:0] m_edge;
    logic [CNTW-1:0] m_glitch;

    task automatic model_step(input logic si, input logic c, input logic r);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            m_level  = 1'b0;
            m_run    = 0;
            m_edge   = '0;
            m_glitch = '0;
        end else begin
            if (si != m_level) begin
                m_run++;
                if (m_run == FILTCYC) begin
                    m_level = si;
                    m_run   = 0;
                    if (si) m_rise = 1'b1;
                    else    m_fall = 1'b1;
                    if (m_edge != CMAX) m_edge = m_edge + 1'b1;
                end
            end else if (m_run > 0) begin
                m_run = 0;
                if (m_glitch != CMAX) m_glitch = m_glitch + 1'b1;
            end
            if (c) begin
                m_edge   = '0;
                m_glitch = '0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, settle past the edge.
    task automatic step(input logic si, input logic c, input logic r);
        bus.sync_in = si;
        bus.clr     = c;
        reset       = r;
        @(posedge clk);
        model_step(si, c, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1);
            total_cnt++;
            if ({bus.level_out, bus.rise_pls, bus.fall_pls} !== 3'b000 ||
                bus.edge_cnt !== 8'd0 || bus.glitch_cnt !== 8'd0)
                $display("FAIL reset_outputs cyc=%0d got lvl=%b r=%b f=%b e=%0d g=%0d want all 0",
                         i, bus.level_out, bus.rise_pls, bus.fall_pls, bus.edge_cnt, bus.glitch_cnt);
            else pass_cnt++;
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            total_cnt++;
            if (bus.level_out !== (i >= 4) || bus.rise_pls !== (i == 4) || bus.fall_pls !== 1'b0)
                $display("FAIL reset_release edge=%0d got lvl=%b r=%b f=%b want lvl=%b r=%b f=0",
                         i, bus.level_out, bus.rise_pls, bus.fall_pls, (i >= 4), (i == 4));
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.edge_cnt !== 8'd1)
            $display("FAIL reset_edge_cnt got %0d want 1", bus.edge_cnt);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            total_cnt++;
            if (bus.level_out !== 1'b0 || bus.rise_pls !== 1'b0 || bus.fall_pls !== 1'b0)
                $display("FAIL glitch_hold cyc=%0d got lvl=%b r=%b f=%b want 0 0 0",
                         i, bus.level_out, bus.rise_pls, bus.fall_pls);
            else pass_cnt++;
        end
        step(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (bus.glitch_cnt !== 8'd1 || bus.edge_cnt !== 8'd0 || bus.level_out !== 1'b0)
            $display("FAIL glitch_count got g=%0d e=%0d lvl=%b want g=1 e=0 lvl=0",
                     bus.glitch_cnt, bus.edge_cnt, bus.level_out);
        else pass_cnt++;
    endtask

    task automatic test_fall();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (bus.level_out !== 1'b1 || bus.edge_cnt !== 8'd1)
            $display("FAIL fall_setup got lvl=%b e=%0d want lvl=1 e=1", bus.level_out, bus.edge_cnt);
        else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total_cnt++;
            if (bus.level_out !== (i < 4) || bus.fall_pls !== (i == 4) || bus.rise_pls !== 1'b0)
                $display("FAIL fall_seq edge=%0d got lvl=%b r=%b f=%b want lvl=%b r=0 f=%b",
                         i, bus.level_out, bus.rise_pls, bus.fall_pls, (i < 4), (i == 4));
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.edge_cnt !== 8'd2)
            $display("FAIL fall_edge_cnt got %0d want 2", bus.edge_cnt);
        else pass_cnt++;
    endtask

    task automatic test_clr_priority();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (bus.edge_cnt !== 8'd0 || bus.rise_pls !== 1'b1 || bus.level_out !== 1'b1)
            $display("FAIL clr_priority got e=%0d r=%b lvl=%b want e=0 r=1 lvl=1",
                     bus.edge_cnt, bus.rise_pls, bus.level_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_qual();
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        total_cnt++;
        if (bus.rise_pls !== 1'b0 || bus.level_out !== 1'b0 || bus.edge_cnt !== 8'd0)
            $display("FAIL midqual_reset got r=%b lvl=%b e=%0d want 0 0 0",
                     bus.rise_pls, bus.level_out, bus.edge_cnt);
        else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            total_cnt++;
            if (bus.level_out !== (i >= 4) || bus.rise_pls !== (i == 4))
                $display("FAIL midqual_release edge=%0d got lvl=%b r=%b want lvl=%b r=%b",
                         i, bus.level_out, bus.rise_pls, (i >= 4), (i == 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 260; n++) begin
            for (int k = 0; k < FILTCYC; k++) step((n % 2) == 0, 1'b0, 1'b0);
            if (n == 254 || n == 259) begin
                total_cnt++;
                if (bus.edge_cnt !== 8'd255)
                    $display("FAIL edge_saturate after=%0d got %0d want 255", n + 1, bus.edge_cnt);
                else pass_cnt++;
            end
        end
        step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 260; n++) begin
            for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        total_cnt++;
        if (bus.glitch_cnt !== 8'd255 || bus.edge_cnt !== 8'd0 || bus.level_out !== 1'b0)
            $display("FAIL glitch_saturate got g=%0d e=%0d lvl=%b want g=255 e=0 lvl=0",
                     bus.glitch_cnt, bus.edge_cnt, bus.level_out);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic si;
        logic c;
        logic r;
        logic [2+2*CNTW:0] got;
        logic [2+2*CNTW:0] exp;
        si = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30) si = ~si;
            c = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 199) == 0);
            step(si, c, r);
            got = {bus.level_out, bus.rise_pls, bus.fall_pls, bus.edge_cnt, bus.glitch_cnt};
            exp = {m_level, m_rise, m_fall, m_edge, m_glitch};
            total_cnt++;
            if (got !== exp)
                $display("FAIL random cyc=%0d got lvl=%b r=%b f=%b e=%0d g=%0d want lvl=%b r=%b f=%b e=%0d g=%0d",
                         i, bus.level_out, bus.rise_pls, bus.fall_pls, bus.edge_cnt, bus.glitch_cnt,
                         m_level, m_rise, m_fall, m_edge, m_glitch);
            else pass_cnt++;
        end
    endtask

    initial begin
        bus.sync_in = 1'b0;
        bus.clr     = 1'b0;
        reset       = 1'b1;
        m_level     = 1'b0;
        m_run       = 0;
        m_rise      = 1'b0;
        m_fall      = 1'b0;
        m_edge      = '0;
        m_glitch    = '0;
        test_reset();
        test_glitch();
        test_fall();
        test_clr_priority();
        test_reset_mid_qual();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
